// File: rtl/bt_cmd_decoder_pkg.sv
// bt_cmd_decoder_pkg: shared frame constants, field positions and parser state encodings
package bt_cmd_decoder_pkg;
  localparam logic [7:0] HDR_DEFAULT = 8'hA5;
  localparam int unsigned DIR_LSB = 0;
  localparam int unsigned THR_LSB = 2;
  localparam int unsigned LSR_BIT = 4;
  localparam logic [1:0] NEUTRAL = 2'b00;
  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    GOT_HDR = 2'd1,
    GOT_CMD = 2'd2
  } state_t;
endpackage

// File: rtl/bt_cmd_decoder_timeout.sv
// timeout_counter: saturating cycle counter; expired holds once LIMIT-1 is reached until clr
module timeout_counter #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign expired = cnt_q == W'(LIMIT - 1);
  always_comb cnt_d = clr ? '0 : (en && !expired) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/bt_cmd_decoder.sv
// bt_cmd_decoder: assembles HDR/CMD/CHK frames from the UART and drives actuator codes with failsafe
module bt_cmd_decoder
  import bt_cmd_decoder_pkg::*;
#(
  parameter logic [7:0]  HDR         = HDR_DEFAULT,
  parameter int unsigned GAP_CYCLES  = 500_000,
  parameter int unsigned WDOG_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       link_up,
  output logic [1:0] direction,
  output logic [1:0] throttle,
  output logic       laser,
  output logic [7:0] led,
  output logic       failsafe,
  output logic       frame_ok,
  output logic       frame_err
);
  state_t     state_q, state_d;
  logic [7:0] cmd_q, cmd_d, led_q, led_d;
  logic [1:0] dir_q, dir_d, thr_q, thr_d;
  logic       laser_q, laser_d, failsafe_q, failsafe_d;
  logic       frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
  logic       accept, gap_exp, wdog_exp;

  timeout_counter #(.LIMIT(GAP_CYCLES)) u_gap (
    .clk(clk), .rst_n(rst_n), .clr(rx_valid || !link_up || state_q == HUNT),
    .en(state_q != HUNT), .expired(gap_exp)
  );

  timeout_counter #(.LIMIT(WDOG_CYCLES)) u_wdog (
    .clk(clk), .rst_n(rst_n), .clr(accept), .en(1'b1), .expired(wdog_exp)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    led_d       = led_q;
    dir_d       = dir_q;
    thr_d       = thr_q;
    laser_d     = laser_q;
    failsafe_d  = failsafe_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    accept      = 1'b0;
    if (!link_up) state_d = HUNT;
    else if (rx_valid) begin
      case (state_q)
        HUNT:    state_d = (rx_byte == HDR) ? GOT_HDR : HUNT;
        GOT_HDR: begin
          cmd_d   = rx_byte;
          state_d = GOT_CMD;
        end
        default: begin
          accept      = rx_byte == ~cmd_q;
          frame_err_d = !accept;
          state_d     = (accept || rx_byte != HDR) ? HUNT : GOT_HDR;
        end
      endcase
    end else if (gap_exp && state_q != HUNT) begin
      frame_err_d = 1'b1;
      state_d     = HUNT;
    end
    // an accept in the watchdog expiry cycle still wins
    if (accept) begin
      dir_d      = cmd_q[DIR_LSB +: 2];
      thr_d      = cmd_q[THR_LSB +: 2];
      laser_d    = cmd_q[LSR_BIT];
      led_d      = cmd_q;
      failsafe_d = 1'b0;
      frame_ok_d = 1'b1;
    end else if (!link_up || wdog_exp) begin
      dir_d      = NEUTRAL;
      thr_d      = NEUTRAL;
      laser_d    = 1'b0;
      failsafe_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= HUNT;
      cmd_q       <= '0;
      led_q       <= '0;
      dir_q       <= NEUTRAL;
      thr_q       <= NEUTRAL;
      laser_q     <= 1'b0;
      failsafe_q  <= 1'b1;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      led_q       <= led_d;
      dir_q       <= dir_d;
      thr_q       <= thr_d;
      laser_q     <= laser_d;
      failsafe_q  <= failsafe_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
    end

  assign direction = dir_q;
  assign throttle  = thr_q;
  assign laser     = laser_q & ~failsafe_q;
  assign led       = led_q;
  assign failsafe  = failsafe_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_bt_cmd_decoder.sv
// tb_bt_cmd_decoder: directed frame scenarios with hand-computed expectations
module tb_bt_cmd_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_byte = '0;
  logic       rx_valid = 1'b0;
  logic       link_up = 1'b1;
  logic [1:0] direction, throttle;
  logic       laser, failsafe, frame_ok, frame_err;
  logic [7:0] led;
  int passed = 0;
  int total = 0;

  bt_cmd_decoder #(.GAP_CYCLES(50), .WDOG_CYCLES(400)) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid), .link_up(link_up),
    .direction(direction), .throttle(throttle), .laser(laser), .led(led),
    .failsafe(failsafe), .frame_ok(frame_ok), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    total++; if (direction !== 2'b00) $display("FAIL reset_dir: got %b want 00", direction); else passed++;
    total++; if (throttle !== 2'b00) $display("FAIL reset_thr: got %b want 00", throttle); else passed++;
    total++; if (laser !== 1'b0) $display("FAIL reset_laser: got %b want 0", laser); else passed++;
    total++; if (led !== 8'h00) $display("FAIL reset_led: got %h want 00", led); else passed++;
    total++; if (failsafe !== 1'b1) $display("FAIL reset_failsafe: got %b want 1", failsafe); else passed++;
    total++; if ({frame_ok, frame_err} !== 2'b00) $display("FAIL reset_pulses: got %b want 00", {frame_ok, frame_err}); else passed++;
  endtask

  task automatic test_good_frame();
    send_byte(8'hA5);
    send_byte(8'h1D);
    total++; if (frame_ok !== 1'b0) $display("FAIL good_early_ok: got %b want 0", frame_ok); else passed++;
    send_byte(8'hE2);
    total++; if (frame_ok !== 1'b1) $display("FAIL good_ok: got %b want 1", frame_ok); else passed++;
    total++; if (direction !== 2'b01) $display("FAIL good_dir: got %b want 01", direction); else passed++;
    total++; if (throttle !== 2'b11) $display("FAIL good_thr: got %b want 11", throttle); else passed++;
    total++; if (laser !== 1'b1) $display("FAIL good_laser: got %b want 1", laser); else passed++;
    total++; if (led !== 8'h1D) $display("FAIL good_led: got %h want 1D", led); else passed++;
    total++; if (failsafe !== 1'b0) $display("FAIL good_failsafe: got %b want 0", failsafe); else passed++;
    idle(1);
    total++; if (frame_ok !== 1'b0) $display("FAIL good_ok_width: got %b want 0", frame_ok); else passed++;
  endtask

  task automatic test_bad_check();
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h05);
    total++; if (frame_err !== 1'b1) $display("FAIL bad_err: got %b want 1", frame_err); else passed++;
    total++; if (frame_ok !== 1'b0) $display("FAIL bad_ok: got %b want 0", frame_ok); else passed++;
    total++; if ({direction, throttle, laser, led} !== {2'b01, 2'b11, 1'b1, 8'h1D})
      $display("FAIL bad_hold: got %b want %b", {direction, throttle, laser, led}, {2'b01, 2'b11, 1'b1, 8'h1D}); else passed++;
    send_byte(8'hA5);
    send_byte(8'hA5);
    send_byte(8'h5A);
    total++; if (frame_ok !== 1'b1) $display("FAIL hdr_payload_ok: got %b want 1", frame_ok); else passed++;
    total++; if ({direction, throttle, laser, led} !== {2'b01, 2'b01, 1'b0, 8'hA5})
      $display("FAIL hdr_payload_out: got %b want %b", {direction, throttle, laser, led}, {2'b01, 2'b01, 1'b0, 8'hA5}); else passed++;
  endtask

  task automatic test_gap_timeout();
    int first = 0;
    int errs = 0;
    send_byte(8'hA5);
    send_byte(8'h06);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (frame_err) begin
        errs++;
        if (first == 0) first = i;
      end
    end
    total++; if (first !== 50) $display("FAIL gap_cycle: got %0d want 50", first); else passed++;
    total++; if (errs !== 1) $display("FAIL gap_pulses: got %0d want 1", errs); else passed++;
    send_byte(8'hF9);
    total++; if ({frame_ok, frame_err} !== 2'b00) $display("FAIL gap_stray_pulse: got %b want 00", {frame_ok, frame_err}); else passed++;
    total++; if ({direction, throttle, led} !== {2'b01, 2'b01, 8'hA5})
      $display("FAIL gap_stray_out: got %b want %b", {direction, throttle, led}, {2'b01, 2'b01, 8'hA5}); else passed++;
  endtask

  task automatic test_watchdog();
    logic fs_seen = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h1D);
    send_byte(8'hE2);
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 399 && failsafe !== 1'b0) fs_seen = 1'b1;
    end
    total++; if (fs_seen !== 1'b0) $display("FAIL wdog_early: got 1 want 0 at cycle 399"); else passed++;
    total++; if (failsafe !== 1'b1) $display("FAIL wdog_failsafe: got %b want 1", failsafe); else passed++;
    total++; if ({direction, throttle, laser} !== 5'b0) $display("FAIL wdog_neutral: got %b want 00000", {direction, throttle, laser}); else passed++;
    total++; if (led !== 8'h1D) $display("FAIL wdog_led: got %h want 1D", led); else passed++;
    send_byte(8'hA5);
    send_byte(8'h1D);
    send_byte(8'hE2);
    total++; if (failsafe !== 1'b0) $display("FAIL wdog_recover: got %b want 0", failsafe); else passed++;
    for (int i = 0; i < 397; i++) begin
      @(negedge clk);
      if (failsafe) fs_seen = 1'b1;
    end
    send_byte(8'hA5);
    send_byte(8'h06);
    if (failsafe) fs_seen = 1'b1;
    send_byte(8'hF9);
    total++; if (frame_ok !== 1'b1) $display("FAIL wdog_edge_ok: got %b want 1", frame_ok); else passed++;
    total++; if ({fs_seen, failsafe} !== 2'b00) $display("FAIL wdog_edge_failsafe: got %b want 00", {fs_seen, failsafe}); else passed++;
    idle(1);
    total++; if (failsafe !== 1'b0) $display("FAIL wdog_edge_after: got %b want 0", failsafe); else passed++;
  endtask

  task automatic test_link_drop();
    logic pulse_seen = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h1D);
    send_byte(8'hE2);
    send_byte(8'hA5);
    link_up = 1'b0;
    @(negedge clk);
    total++; if (failsafe !== 1'b1) $display("FAIL link_failsafe: got %b want 1", failsafe); else passed++;
    total++; if ({direction, throttle, laser} !== 5'b0) $display("FAIL link_neutral: got %b want 00000", {direction, throttle, laser}); else passed++;
    if (frame_err) pulse_seen = 1'b1;
    send_byte(8'h06);
    if (frame_ok || frame_err) pulse_seen = 1'b1;
    send_byte(8'hF9);
    if (frame_ok || frame_err) pulse_seen = 1'b1;
    idle(2);
    if (frame_ok || frame_err) pulse_seen = 1'b1;
    total++; if (pulse_seen !== 1'b0) $display("FAIL link_pulses: got 1 want 0"); else passed++;
    total++; if (failsafe !== 1'b1) $display("FAIL link_hold: got %b want 1", failsafe); else passed++;
    link_up = 1'b1;
    @(negedge clk);
    total++; if (failsafe !== 1'b1) $display("FAIL link_up_no_frame: got %b want 1", failsafe); else passed++;
    send_byte(8'hA5);
    send_byte(8'h06);
    send_byte(8'hF9);
    total++; if ({frame_ok, failsafe} !== 2'b10) $display("FAIL link_recover: got %b want 10", {frame_ok, failsafe}); else passed++;
    total++; if ({direction, throttle, laser, led} !== {2'b10, 2'b01, 1'b0, 8'h06})
      $display("FAIL link_recover_out: got %b want %b", {direction, throttle, laser, led}, {2'b10, 2'b01, 1'b0, 8'h06}); else passed++;
  endtask

  task automatic test_async_reset();
    send_byte(8'hA5);
    send_byte(8'h1D);
    send_byte(8'hE2);
    send_byte(8'hA5);
    send_byte(8'h1D);
    #1 rst_n = 1'b0;
    #1;
    total++; if ({direction, throttle, laser, led, failsafe} !== {13'b0, 1'b1})
      $display("FAIL arst_immediate: got %b want %b", {direction, throttle, laser, led, failsafe}, {13'b0, 1'b1}); else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'hE2);
    total++; if ({frame_ok, frame_err} !== 2'b00) $display("FAIL arst_chk_pulse: got %b want 00", {frame_ok, frame_err}); else passed++;
    total++; if ({direction, throttle, laser, led, failsafe} !== {13'b0, 1'b1})
      $display("FAIL arst_chk_out: got %b want %b", {direction, throttle, laser, led, failsafe}, {13'b0, 1'b1}); else passed++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_good_frame();
    test_bad_check();
    test_gap_timeout();
    test_watchdog();
    test_link_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
